// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and rotating-priority pick for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic [0:0] {IDLE, XFER} arb_state_t;

  localparam int RR_MAX_N = 8;

  // Scans ptr, ptr+1, ... modulo n; wrap is an explicit subtract so n need not be a power of 2.
  function automatic logic rr_pick(input logic [RR_MAX_N-1:0] valid, input int ptr,
                                   input int n, output int idx);
    logic found;
    int   cand;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      cand = ptr + k;
      if (cand >= n) cand = cand - n;
      if (k < n && !found && valid[cand[2:0]]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating-priority selector over N request bits
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int  N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           found
);

  logic [RR_MAX_N-1:0] valid_ext;
  int                  idx_int;

  always_comb begin
    valid_ext        = '0;
    valid_ext[N-1:0] = valid;
    idx_int          = 0;
    found            = rr_pick(valid_ext, int'(ptr), N, idx_int);
    idx              = IDW'(idx_int);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-locked round-robin owner of the async FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  N         = 4,
  parameter int  DW        = 8,
  parameter int  MAX_BEATS = 16,
  localparam int IDW       = $clog2(N)
) (
  input  logic            clk_w,
  input  logic            arst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  output logic            fifo_w_en,
  output logic [DW-1:0]   fifo_w_data,
  output logic [IDW-1:0]  grant_id,
  output logic            busy,
  output logic            ovl_err
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  arb_state_t     state, state_next;
  logic [IDW-1:0] rr_ptr, rr_ptr_next, grant_next, pick_idx;
  logic [CW-1:0]  beat_cnt, beat_cnt_next;
  logic           ovl_next, pick_found;
  logic           own_valid, own_last;

  rr_priority_pick #(.N(N)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign own_valid = req_valid[grant_id];
  assign own_last  = req_last[grant_id];

  always_ff @(posedge clk_w or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      ovl_err  <= 1'b0;
    end else begin
      state    <= state_next;
      grant_id <= grant_next;
      rr_ptr   <= rr_ptr_next;
      beat_cnt <= beat_cnt_next;
      ovl_err  <= ovl_next;
    end
  end

  // Ready is a function of state, owner and full only, so it never loops back through req_valid.
  always_comb begin
    state_next    = state;
    grant_next    = grant_id;
    rr_ptr_next   = rr_ptr;
    beat_cnt_next = beat_cnt;
    ovl_next      = ovl_err;
    req_ready     = '0;
    fifo_w_en     = 1'b0;
    fifo_w_data   = '0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          state_next = XFER;
        end
      end
      XFER: begin
        busy                = 1'b1;
        req_ready[grant_id] = !fifo_full;
        fifo_w_en           = own_valid && !fifo_full;
        fifo_w_data         = req_data[grant_id*DW +: DW];
        if (fifo_w_en) begin
          if (beat_cnt != CW'(MAX_BEATS)) beat_cnt_next = beat_cnt + CW'(1);
          else if (!own_last)             ovl_next      = 1'b1;
          if (own_last) begin
            state_next    = IDLE;
            beat_cnt_next = '0;
            rr_ptr_next   = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter against a packet-level model
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic          clk_w = 1'b0;
  logic          arst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_w_data;
  logic [1:0]    grant_id;
  logic          busy;
  logic          ovl_err;

  always #5 clk_w = ~clk_w;

  fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BEATS(MB)) dut (
    .clk_w       (clk_w),
    .arst_n      (arst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_w_data (fifo_w_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .ovl_err     (ovl_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each requester's pending beats as {last, data}, oldest first.
  logic [8:0] srcq [N][$];
  bit rand_mode  = 0;
  bit full_force = 0;

  always @(posedge clk_w) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = srcq[i][0][7:0];
        req_last[i]          = srcq[i][0][8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = 8'($urandom);
        req_last[i]          = 1'($urandom);
      end
    end
    fifo_full = rand_mode ? ($urandom_range(4) == 0) : full_force;
  end

  // Packet-level model: who owns the port, where the next scan starts, beats taken so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_ovl   = 0;
  bit m_last;

  always @(posedge clk_w or negedge arst_n) begin
    if (!arst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_ovl   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
        end
    end else if (req_valid[m_owner] && !fifo_full && srcq[m_owner].size() > 0) begin
      m_last = srcq[m_owner][0][8];
      void'(srcq[m_owner].pop_front());
      if (m_cnt == MB && !m_last) m_ovl = 1;
      if (m_cnt < MB) m_cnt++;
      if (m_last) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
  end

  int         cyc = 0;
  logic [9:0] wlog [$];
  int         wcyc [$];
  int         glog [$];
  bit         prev_busy = 0;
  int         v2_cyc = -1;
  int         ovl_rise_cyc = -1;
  logic [N-1:0] exp_ready;
  logic       exp_wen;

  always @(negedge clk_w) begin
    cyc++;
    if (arst_n === 1'b1) begin
      exp_ready = (m_owner >= 0 && !fifo_full) ? (4'(1) << m_owner) : 4'(0);
      exp_wen   = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
      chk("busy", busy, m_owner >= 0);
      chk("req_ready", req_ready, exp_ready);
      chk("fifo_w_en", fifo_w_en, exp_wen);
      chk("ovl_err", ovl_err, m_ovl);
      if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
      if (exp_wen) chk("fifo_w_data", fifo_w_data, srcq[m_owner][0][7:0]);
      if (fifo_w_en) begin
        wlog.push_back({grant_id, fifo_w_data});
        wcyc.push_back(cyc);
      end
      if (busy && !prev_busy) glog.push_back(int'(grant_id));
      if (req_valid[2] && v2_cyc < 0) v2_cyc = cyc;
      if (ovl_err && ovl_rise_cyc < 0) ovl_rise_cyc = cyc;
    end
    prev_busy = busy;
  end

  task automatic step();
    @(posedge clk_w);
    #2;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (!(all_empty() && m_owner < 0) && t < budget) begin
      step();
      t++;
    end
    step();
    chk(name, t < budget, 1);
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int t = 0;
    while (wlog.size() < n && t < budget) begin
      step();
      t++;
    end
    chk(name, t < budget, 1);
  endtask

  task automatic clear_logs();
    wlog.delete();
    wcyc.delete();
    glog.delete();
  endtask

  task automatic push_pkt(input int r, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) srcq[r].push_back({(k == len - 1), 8'(base + k)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk_w);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_w_en", fifo_w_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ovl", ovl_err, 0);
    arst_n = 1'b1;

    // Requester 2, three beats.
    step();
    clear_logs();
    v2_cyc = -1;
    push_pkt(2, 3, 8'hA0);
    wait_idle(20, "t1_drain");
    chk("t1_nwrites", wlog.size(), 3);
    chk("t1_beat0", wlog[0], {2'd2, 8'hA0});
    chk("t1_beat1", wlog[1], {2'd2, 8'hA1});
    chk("t1_beat2", wlog[2], {2'd2, 8'hA2});
    chk("t1_latency", wcyc[0] - v2_cyc, 1);
    chk("t1_span", wcyc[2] - wcyc[0], 2);
    chk("t1_busy_end", busy, 0);

    // Continuous single-beat packets from everyone; scan resumes after requester 2.
    clear_logs();
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < N; i++) push_pkt(i, 1, 8'(16 * i + rep));
    wait_idle(40, "t2_drain");
    chk("t2_ngrants", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) chk("t2_grant_order", glog[k], (3 + k) % N);
    for (int k = 1; k < wcyc.size(); k++) chk("t2_pkt_period", wcyc[k] - wcyc[k-1], 2);

    // Requester 1 stalled by full for five cycles.
    clear_logs();
    push_pkt(1, 6, 8'h10);
    wait_writes(2, 20, "t3_start");
    full_force = 1;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_ready_held", req_ready[1], 0);
      chk("t3_wen_held", fifo_w_en, 0);
    end
    full_force = 0;
    wait_idle(30, "t3_drain");
    chk("t3_nwrites", wlog.size(), 6);
    for (int k = 0; k < 6 && k < wlog.size(); k++) chk("t3_order", wlog[k], {2'd1, 8'(8'h10 + k)});

    // Requester 3 arrives while requester 0 owns the port.
    clear_logs();
    push_pkt(0, 2, 8'h20);
    begin
      int t = 0;
      while (!busy && t < 10) begin step(); t++; end
      chk("t4_grant0", t < 10, 1);
    end
    push_pkt(3, 1, 8'h30);
    step();
    chk("t4_r3_not_ready", req_ready[3], 0);
    wait_idle(20, "t4_drain");
    chk("t4_nwrites", wlog.size(), 3);
    chk("t4_w0", wlog[0], {2'd0, 8'h20});
    chk("t4_w1", wlog[1], {2'd0, 8'h21});
    chk("t4_w2", wlog[2], {2'd3, 8'h30});

    // Over-length packet: 18 beats, last on the 18th.
    clear_logs();
    ovl_rise_cyc = -1;
    push_pkt(1, 18, 8'h40);
    wait_idle(40, "t5_drain");
    chk("t5_nwrites", wlog.size(), 18);
    for (int k = 0; k < 18 && k < wlog.size(); k++) chk("t5_order", wlog[k], {2'd1, 8'(8'h40 + k)});
    chk("t5_ovl_set", ovl_err, 1);
    if (wcyc.size() >= 17) chk("t5_ovl_rise", ovl_rise_cyc, wcyc[16] + 1);

    // Randomized traffic and back-pressure.
    rand_mode = 1;
    for (int p = 0; p < 60; p++) begin
      push_pkt($urandom_range(N - 1), $urandom_range(1, 6), 8'($urandom));
      repeat ($urandom_range(3)) step();
    end
    wait_idle(3000, "rand_drain");
    rand_mode = 0;
    chk("rand_ovl_sticky", ovl_err, 1);

    // Asynchronous reset in the middle of a packet.
    clear_logs();
    push_pkt(2, 6, 8'h60);
    wait_writes(2, 20, "t6_start");
    @(posedge clk_w);
    #3;
    arst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_w_en", fifo_w_en, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_grant", grant_id, 0);
    chk("t6_ovl", ovl_err, 0);
    chk("t6_data", fifo_w_data, 0);
    for (int i = 0; i < N; i++) srcq[i].delete();
    repeat (2) @(posedge clk_w);
    #1;
    arst_n = 1'b1;
    step();
    clear_logs();
    push_pkt(3, 1, 8'h55);
    wait_idle(20, "t6_drain");
    chk("t6_ngrants", glog.size(), 1);
    if (glog.size() > 0) chk("t6_grant3", glog[0], 3);
    if (wlog.size() > 0) chk("t6_write", wlog[0], {2'd3, 8'h55});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
